// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : AES-128 types, S-box, round helper functions and controller states.
// Rev     : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS_128 = 10;

    // state[r][c]; byte (4c+r) of the 128-bit vector, byte 0 in bits [127:120]
    typedef logic [0:3][0:3][7:0] state_t;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t vec2state(input logic [127:0] v);
        state_t s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = v[127 - 8*(4*c + r) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] state2vec(input state_t s);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[127 - 8*(4*c + r) -: 8] = s[r][c];
        return v;
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = sbox(s[r][c]);
        return o;
    endfunction

    // row r rotates left by r columns
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = s[r][(c + r) % 4];
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[0][c];
            a1 = s[1][c];
            a2 = s[2][c];
            a3 = s[3][c];
            o[0][c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[1][c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[2][c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[3][c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module : aes_key_step
// Brief  : One AES-128 key-expansion step: current round key -> next round key.
// Rev    : 1.0  initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_key;

    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
// Module : aes_round
// Brief  : Full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// Rev    : 1.0  initial release
// ============================================================================
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    output logic [127:0] o_state
);

    assign o_state = state2vec(mix_columns(shift_rows(sub_bytes(vec2state(i_state)))))
                     ^ i_round_key;

endmodule
`default_nettype wire

// File: rtl/aes128_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes128_iter_ctrl
// Brief  : Iterative AES-128 encryptor, one round per cycle, on-the-fly keys.
// Rev    : 1.0  initial release
// ============================================================================
module aes128_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic [3:0]   round_idx
);

    generate
        if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_num_rounds
            $fatal(1, "aes128_iter_ctrl: NUM_ROUNDS must be 10");
        end
    endgenerate

    logic [1:0]   r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [3:0]   r_rnd;

    logic [127:0] w_nk;
    logic [127:0] w_round;
    logic [127:0] w_final;

    aes_key_step u_key_step (
        .i_key  (r_rk),
        .i_rcon (rcon(r_rnd)),
        .o_key  (w_nk)
    );

    aes_round u_round (
        .i_state     (r_state),
        .i_round_key (w_nk),
        .o_state     (w_round)
    );

    // Last round skips MixColumns
    assign w_final = state2vec(shift_rows(sub_bytes(vec2state(r_state)))) ^ w_nk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= c_IDLE;
            r_state <= '0;
            r_rk    <= '0;
            r_rnd   <= 4'd0;
        end else begin
            case (r_fsm)
                c_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_text ^ in_key;
                        r_rk    <= in_key;
                        r_rnd   <= 4'd1;
                        r_fsm   <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_rk <= w_nk;
                    if (r_rnd == 4'(NUM_ROUNDS)) begin
                        r_state <= w_final;
                        r_fsm   <= c_DONE;
                    end else begin
                        r_state <= w_round;
                        r_rnd   <= r_rnd + 4'd1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_rnd <= 4'd0;
                        r_fsm <= c_IDLE;
                    end
                end
                default: r_fsm <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == c_IDLE);
    assign out_valid = (r_fsm == c_DONE);
    assign busy      = (r_fsm != c_IDLE);
    assign round_idx = r_rnd;
    assign out_text  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_aes128_iter_ctrl
// Brief  : Self-checking bench for aes128_iter_ctrl against an AES reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aes128_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic [3:0]   round_idx;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_m [256];

    aes128_iter_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (GF arithmetic, full key schedule) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            rk = model_round_key(key, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction: offer, track latency, optional RUN noise, hold, drain.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input int hold, input bit noise, output logic [127:0] got);
        logic [127:0] exp;
        int cyc;
        exp = model_encrypt(key, pt);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_text  = pt;
        in_key   = key;
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            if (noise && cyc < 9) begin
                in_valid = 1'b1;
                in_text  = rand128();
                in_key   = rand128();
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == 2) chk({tag, "_rk1"}, dut.r_rk, model_round_key(key, 1));
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 128'(cyc), 128'd11);
        chk({tag, "_result"}, out_text, exp);
        got = out_text;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold"}, {out_valid, in_ready, out_text}, {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain"}, {out_valid, busy, in_ready, round_idx}, {1'b0, 1'b0, 1'b1, 4'd0});
    endtask

    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin : main
        logic [127:0] got;
        logic [127:0] bk [3];
        logic [127:0] bp [3];
        logic [127:0] bo [3];
        int           bt [3];
        int           idx;
        int           nout;
        int           cyc;
        logic         acc;

        for (int x = 0; x < 256; x++) begin
            logic [7:0]  inv;
            logic [15:0] d;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            d = {inv, inv};
            sb_m[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
        step(); step(); step();
        rst = 1'b0;
        chk("reset_state", {in_ready, out_valid, busy, round_idx, out_text},
            {1'b1, 1'b0, 1'b0, 4'd0, 128'd0});

        // Zero key and plaintext
        run_block("zero", 128'd0, 128'd0, 0, 1'b0, got);
        chk("zero_kat", got, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        chk("zero_rk1_kat", model_round_key(128'd0, 1), 128'h62636363626363636263636362636363);

        run_block("fips", K2, P2, 0, 1'b0, got);
        chk("fips_kat", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Consumer back-pressure for 20 cycles
        run_block("hold", K3, P3, 20, 1'b0, got);
        chk("hold_kat", got, 128'h3925841d02dc09fbdc118597196a0b32);

        // in_valid churning while RUN must be ignored
        run_block("noise", K2, P2, 2, 1'b1, got);
        chk("noise_kat", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Reset mid-block
        in_valid = 1'b1; in_text = P3; in_key = K3;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (round_idx != 4'd5 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("midrst_reach5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outputs", {in_ready, out_valid, busy, round_idx, out_text},
            {1'b1, 1'b0, 1'b0, 4'd0, 128'd0});
        chk("midrst_regs", {dut.r_state, dut.r_rk}, 256'd0);
        run_block("after_rst", K3, P3, 0, 1'b0, got);
        chk("after_rst_kat", got, 128'h3925841d02dc09fbdc118597196a0b32);

        // Random blocks against the model
        for (int n = 0; n < 4; n++)
            run_block($sformatf("rand%0d", n), rand128(), rand128(),
                      int'($urandom_range(0, 3)), n[0], got);

        // Back-to-back with in_valid and out_ready held high
        bk[0] = 128'd0; bp[0] = 128'd0;
        bk[1] = K2;     bp[1] = P2;
        bk[2] = rand128(); bp[2] = rand128();
        idx = 0; nout = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_key = bk[0]; in_text = bp[0];
        for (int c = 0; c < 80 && nout < 3; c++) begin
            if (out_valid) begin
                bo[nout] = out_text;
                bt[nout] = c;
                nout++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    in_key = bk[idx]; in_text = bp[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(nout), 128'd3);
        for (int i = 0; i < nout; i++)
            chk($sformatf("b2b_result%0d", i), bo[i], model_encrypt(bk[i], bp[i]));
        if (nout == 3) begin
            chk("b2b_spacing01", 128'(bt[1] - bt[0]), 128'd12);
            chk("b2b_spacing12", 128'(bt[2] - bt[1]), 128'd12);
        end
        step();
        chk("final_idle", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
